// File: rtl/control_riesgos.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: stalls, bubbles, branch flush, stall counter.
// Optional EX/WB operand bypassing is enabled with the CONTROL_RIESGOS_FORWARD_EN macro.
module control_riesgos #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       hit_e_a, hit_e_b, hit_w_a, hit_w_b;
    logic       hit_e, hit_w;
    logic       stall_req, go_hold, stall;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    assign hit_e_a = id_valid & ex_regwrite & (ex_rd == id_rs) & (id_rs != '0);
    assign hit_e_b = id_valid & id_use_rt & ex_regwrite & (ex_rd == id_rt) & (id_rt != '0);
    assign hit_w_a = id_valid & wb_regwrite & (wb_rd == id_rs) & (id_rs != '0);
    assign hit_w_b = id_valid & id_use_rt & wb_regwrite & (wb_rd == id_rt) & (id_rt != '0);
    assign hit_e   = hit_e_a | hit_e_b;
    assign hit_w   = hit_w_a | hit_w_b;

`ifdef CONTROL_RIESGOS_FORWARD_EN
    // Only a load in EX has no result yet; one stall turns it into a WB bypass.
    assign stall_req = hit_e & ex_memread;
    assign go_hold   = 1'b0;
    assign fwd_a_sel = hit_e_a ? 2'b01 : (hit_w_a ? 2'b10 : 2'b00);
    assign fwd_b_sel = hit_e_b ? 2'b01 : (hit_w_b ? 2'b10 : 2'b00);
`else
    // Without bypassing, any EX producer (load or ALU) must reach past WB: two stalls.
    assign stall_req = hit_e | hit_w;
    assign go_hold   = (hit_e & ex_memread) | (hit_e & ~ex_memread);
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    assign stall = (state == HOLD) | stall_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (branch_taken)          state_nxt = RUN;
        else if (state == HOLD)    state_nxt = RUN;
        else if (stall_req && go_hold) state_nxt = HOLD;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst_n) begin
            if (branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                fwd_a = fwd_a_sel;
                fwd_b = fwd_b_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (!pc_en && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_control_riesgos.sv
// Bench for control_riesgos: directed vector table, multi-cycle sequences, random traffic vs. a reference model.
module tb_control_riesgos;

`ifdef CONTROL_RIESGOS_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CMAX = 65535;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rt, ex_regwrite, ex_memread, wb_regwrite, branch_taken;
    logic [4:0] id_rs, id_rt, ex_rd, wb_rd;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_count;

    int checks = 0;
    int failures = 0;
    int owed = 0;
    int mcount = 0;

    control_riesgos #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic       use_rt;
        logic [4:0] exrd;
        logic       exw, exm;
        logic [4:0] wbrd;
        logic       wbw, br;
        logic       st_nf, st_fw;
        logic [1:0] fa_fw, fb_fw;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic u, logic [4:0] exrd,
                                logic exw, logic exm, logic [4:0] wbrd, logic wbw, logic br,
                                logic st_nf, logic st_fw, logic [1:0] fa, logic [1:0] fb);
        vec_t r;
        r.valid = v; r.rs = rs; r.rt = rt; r.use_rt = u; r.exrd = exrd; r.exw = exw; r.exm = exm;
        r.wbrd = wbrd; r.wbw = wbw; r.br = br; r.st_nf = st_nf; r.st_fw = st_fw; r.fa_fw = fa; r.fb_fw = fb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic u,
                         input logic [4:0] exrd, input logic exw, input logic exm,
                         input logic [4:0] wbrd, input logic wbw, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rt = u; ex_rd = exrd; ex_regwrite = exw;
        ex_memread = exm; wb_rd = wbrd; wb_regwrite = wbw; branch_taken = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic bit hit(logic v, logic we, logic [4:0] rd, logic [4:0] x);
        return v && we && (rd == x) && (x != 0);
    endfunction

    // Reference: "owed" counts stall cycles still due; compare, then advance to the next edge.
    task automatic model_check();
        bit ea, eb, wa, wb, st;
        int owed_n;
        int efa, efb;
        ea = hit(id_valid, ex_regwrite, ex_rd, id_rs);
        eb = id_use_rt && hit(id_valid, ex_regwrite, ex_rd, id_rt);
        wa = hit(id_valid, wb_regwrite, wb_rd, id_rs);
        wb = id_use_rt && hit(id_valid, wb_regwrite, wb_rd, id_rt);
        efa = 0; efb = 0;
        if (branch_taken) begin
            st = 0; owed_n = 0;
        end else if (owed > 0) begin
            st = 1; owed_n = owed - 1;
        end else if (FWD) begin
            st = (ea || eb) && ex_memread;
            owed_n = 0;
            if (!st) begin
                efa = ea ? 1 : (wa ? 2 : 0);
                efb = eb ? 1 : (wb ? 2 : 0);
            end
        end else begin
            st = ea || eb || wa || wb;
            owed_n = (ea || eb) ? 1 : 0;
        end
        check("pc_en", pc_en, !st);
        check("ifid_en", ifid_en, !st);
        check("ifid_flush", ifid_flush, branch_taken);
        check("idex_bubble", idex_bubble, st || branch_taken);
        check("fwd_a", fwd_a, efa);
        check("fwd_b", fwd_b, efb);
        check("stall_count", stall_count, mcount);
        if (st && mcount < CMAX) mcount++;
        owed = owed_n;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    int c0;
    logic st_exp;

    initial begin
        tbl[0] = mk(1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00);
        tbl[1] = mk(1, 0, 5, 1, 0, 0, 0, 5, 1, 0, 1, 0, 2'b00, 2'b10);
        tbl[2] = mk(1, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00);
        tbl[3] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        tbl[4] = mk(1, 7, 0, 0, 7, 1, 0, 7, 1, 0, 1, 0, 2'b01, 2'b00);
        tbl[5] = mk(1, 0, 7, 1, 7, 1, 1, 0, 0, 0, 1, 1, 2'b00, 2'b00);
        tbl[6] = mk(0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
        tbl[7] = mk(1, 3, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        tbl[8] = mk(1, 4, 4, 1, 4, 0, 0, 4, 1, 0, 1, 0, 2'b10, 2'b10);
        tbl[9] = mk(1, 2, 6, 1, 6, 1, 0, 2, 1, 0, 1, 0, 2'b10, 2'b01);

        // Reset with a hazard on the inputs: outputs must still show reset values.
        rst_n = 1'b0;
        drive(1, 3, 0, 0, 3, 1, 0, 0, 0, 0);
        #1;
        check("rst_pc_en", pc_en, 1);
        check("rst_bubble", idex_bubble, 0);
        check("rst_flush", ifid_flush, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_count", stall_count, 0);
        repeat (2) @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        owed = 0; mcount = 0;
        cycle();

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].use_rt, tbl[i].exrd, tbl[i].exw,
                  tbl[i].exm, tbl[i].wbrd, tbl[i].wbw, tbl[i].br);
            st_exp = FWD ? tbl[i].st_fw : tbl[i].st_nf;
            @(negedge clk);
            check($sformatf("tbl%0d_pc_en", i), pc_en, !st_exp);
            check($sformatf("tbl%0d_flush", i), ifid_flush, tbl[i].br);
            check($sformatf("tbl%0d_bubble", i), idex_bubble, st_exp || tbl[i].br);
            check($sformatf("tbl%0d_fwd_a", i), fwd_a, FWD ? tbl[i].fa_fw : 2'b00);
            check($sformatf("tbl%0d_fwd_b", i), fwd_b, FWD ? tbl[i].fb_fw : 2'b00);
            model_check();
            @(posedge clk);
            #1;
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            cycle();
        end
        idle();
        cycle();

        // EX dependency: two stalls (RUN->HOLD->RUN) unless bypassed.
        c0 = mcount;
        drive(1, 3, 0, 0, 3, 1, 0, 0, 0, 0);
        @(negedge clk); check("seqA_c1_pc_en", pc_en, FWD ? 1 : 0); model_check(); @(posedge clk); #1;
        idle();
        @(negedge clk); check("seqA_c2_pc_en", pc_en, FWD ? 1 : 0); model_check(); @(posedge clk); #1;
        @(negedge clk); check("seqA_c3_pc_en", pc_en, 1);
        check("seqA_count", stall_count, c0 + (FWD ? 0 : 2)); model_check(); @(posedge clk); #1;

        // Branch arriving in the stall's second cycle flushes and is not counted.
        c0 = mcount;
        drive(1, 3, 0, 0, 3, 1, 1, 0, 0, 0);
        @(negedge clk); check("seqB_stall", pc_en, 0); model_check(); @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("seqB_flush", ifid_flush, 1);
        check("seqB_bubble", idex_bubble, 1);
        check("seqB_pc_en", pc_en, 1);
        model_check(); @(posedge clk); #1;
        idle();
        @(negedge clk); check("seqB_run_pc_en", pc_en, 1);
        check("seqB_count", stall_count, c0 + 1); model_check(); @(posedge clk); #1;

        // Load-use on rt: one stall, then the value is taken from WB.
        drive(1, 0, 7, 1, 7, 1, 1, 0, 0, 0);
        @(negedge clk); check("seqC_stall", pc_en, 0); model_check(); @(posedge clk); #1;
        drive(1, 0, 7, 1, 0, 0, 0, 7, 1, 0);
        @(negedge clk);
        check("seqC_next_pc_en", pc_en, FWD ? 1 : 0);
        check("seqC_next_fwd_b", fwd_b, FWD ? 2'b10 : 2'b00);
        model_check(); @(posedge clk); #1;
        idle();
        repeat (3) cycle();

        // Random traffic over a small register range so hits are frequent.
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0);
            cycle();
        end
        idle();
        repeat (2) cycle();

        // Asynchronous reset in the middle of a stall.
        drive(1, 3, 0, 0, 3, 1, 1, 0, 0, 0);
        cycle();
        @(negedge clk);
        check("seqD_pre_pc_en", pc_en, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("seqD_pc_en", pc_en, 1);
        check("seqD_ifid_en", ifid_en, 1);
        check("seqD_bubble", idex_bubble, 0);
        check("seqD_flush", ifid_flush, 0);
        check("seqD_fwd_b", fwd_b, 0);
        check("seqD_count", stall_count, 0);
        owed = 0; mcount = 0;
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // Saturation: continuous stalls drive the counter to its ceiling.
        drive(1, 3, 0, 0, 3, 1, 1, 0, 0, 0);
        repeat (65534) @(posedge clk);
        #1;
        check("seqE_fffe", stall_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("seqE_sat%0d", k), stall_count, 16'hFFFF);
        end
        check("seqE_pc_en", pc_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
